// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the core memory stage (master) and dmem_lsu (slave).
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// Byte/half/word load-store unit over a byte-lane-writable word RAM.
// Define DMEM_MISALIGNED_EN to serve word-crossing accesses in a second internal cycle.
module dmem_lsu #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input logic       clk,
  input logic       reset,
  dmem_lsu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
`ifdef DMEM_MISALIGNED_EN
    SPLIT,
`endif
    RESP
  } state_t;

  state_t state;

  logic [31:0] mem [DEPTH_WORDS];

  logic             ready, accept, err, size_bad, range_bad;
  logic [IDX_W-1:0] idx, rd_idx, wr_idx;
  logic [1:0]       off;
  logic [3:0]       base_be, lo_be, wr_be;
  logic [31:0]      lo_data, wr_data, rd_word;
  logic             wr_en;
  logic             valid_q, err_q;
  logic [31:0]      rdata_q;

`ifdef DMEM_MISALIGNED_EN
  logic [2:0]       nbytes;
  logic             crosses, split_go;
  logic [3:0]       hi_be, hi_be_q;
  logic [31:0]      hi_data, hi_data_q, lo_q, split_raw;
  logic             we_q, uns_q;
  logic [1:0]       off_q, size_q;
  logic [IDX_W-1:0] idx_q;
`else
  logic             misal;
`endif

  function automatic logic [31:0] ext_load(input logic [31:0] raw, input logic [1:0] size,
                                           input logic uns);
    case (size)
      2'b00:   ext_load = {{24{~uns & raw[7]}}, raw[7:0]};
      2'b01:   ext_load = {{16{~uns & raw[15]}}, raw[15:0]};
      default: ext_load = raw;
    endcase
  endfunction

  assign ready          = (state == IDLE) && !reset;
  assign accept         = bus.req_valid && ready;
  assign bus.req_ready  = ready;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // Decode the live request; every legality decision is made here, before anything is written.
  always_comb begin
    idx       = bus.req_addr[IDX_W+1:2];
    off       = bus.req_addr[1:0];
    case (bus.req_size)
      2'b00:   base_be = 4'b0001;
      2'b01:   base_be = 4'b0011;
      default: base_be = 4'b1111;
    endcase
    size_bad  = (bus.req_size == 2'b11);
    range_bad = (bus.req_addr >> (IDX_W + 2)) != 32'd0;
    lo_be     = base_be << off;
    lo_data   = bus.req_wdata << {off, 3'b000};
`ifdef DMEM_MISALIGNED_EN
    case (bus.req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    crosses   = ({1'b0, off} + nbytes) > 3'd4;
    hi_be     = base_be >> (3'd4 - {1'b0, off});
    hi_data   = bus.req_wdata >> {(3'd4 - {1'b0, off}), 3'b000};
    err       = size_bad || range_bad || (crosses && (idx == '1));
    split_go  = crosses && !err;
`else
    misal     = ((bus.req_size == 2'b01) && off[0]) || ((bus.req_size == 2'b10) && (off != 2'b00));
    err       = size_bad || range_bad || misal;
`endif
  end

  always_comb begin
    wr_en   = accept && bus.req_we && !err;
    wr_idx  = idx;
    wr_be   = lo_be;
    wr_data = lo_data;
    rd_idx  = idx;
`ifdef DMEM_MISALIGNED_EN
    // Second word of a split; a reset arriving in this cycle drops it.
    if (state == SPLIT) begin
      wr_en   = we_q && !reset;
      wr_idx  = idx_q + IDX_W'(1);
      wr_be   = hi_be_q;
      wr_data = hi_data_q;
      rd_idx  = idx_q + IDX_W'(1);
    end
    split_raw = (lo_q >> {off_q, 3'b000}) | (rd_word << {(3'd4 - {1'b0, off_q}), 3'b000});
`endif
  end

  assign rd_word = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
`ifdef DMEM_MISALIGNED_EN
            we_q      <= bus.req_we;
            uns_q     <= bus.req_unsigned;
            off_q     <= off;
            size_q    <= bus.req_size;
            idx_q     <= idx;
            lo_q      <= rd_word;
            hi_be_q   <= hi_be;
            hi_data_q <= hi_data;
            if (split_go) begin
              state <= SPLIT;
            end else
`endif
            begin
              state   <= RESP;
              valid_q <= 1'b1;
              err_q   <= err;
              rdata_q <= (err || bus.req_we) ? '0 :
                         ext_load(rd_word >> {off, 3'b000}, bus.req_size, bus.req_unsigned);
            end
          end
        end
`ifdef DMEM_MISALIGNED_EN
        SPLIT: begin
          state   <= RESP;
          valid_q <= 1'b1;
          err_q   <= 1'b0;
          rdata_q <= we_q ? '0 : ext_load(split_raw, size_q, uns_q);
        end
`endif
        RESP: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
